// File: rtl/bin2x2_filter.sv
// 2x2 non-overlapping binning filter: averages each 2x2 block of a raster-order
// pixel stream into one output pixel, with valid/ready handshaking and end-of-frame marker.
module bin2x2_filter #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int W    = PIXEL_BIT_WIDTH;
  localparam int CW   = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int RW   = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int HALF = IN_COLS / 2;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CW-1:0] COL_MAX = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IN_ROWS - 1);

  // Floor average of a 4-pixel sum: drop the two LSBs.
  function automatic logic [W-1:0] avg4(input logic [W+1:0] sum);
    return sum[W+1:2];
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [W-1:0]  pair_q, pair_d;
  logic [W-1:0]  pix_q, pix_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;

  logic [W:0]    line_buf [HALF];

  logic          xfer;
  logic          col_last;
  logic          row_last;
  logic          blk_done;
  logic          lb_we;
  logic [LW-1:0] lb_idx;
  logic [W:0]    pair_sum;
  logic [W:0]    lb_rd;
  logic [W+1:0]  total;

  assign in_ready  = !vld_q || out_ready;
  assign xfer      = in_valid && in_ready;
  assign col_last  = (col_q == COL_MAX);
  assign row_last  = (row_q == ROW_MAX);

  // Odd column closes a horizontal pair; odd row closes a 2x2 block.
  assign blk_done  = xfer && col_q[0] && row_q[0];
  assign lb_we     = xfer && col_q[0] && !row_q[0];
  assign lb_idx    = LW'(col_q >> 1);

  assign pair_sum  = {1'b0, pair_q} + {1'b0, pixel_in};
  assign lb_rd     = line_buf[lb_idx];
  assign total     = {1'b0, lb_rd} + {1'b0, pair_sum};

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    pair_d = pair_q;
    pix_d  = pix_q;
    vld_d  = vld_q;
    last_d = last_q;

    if (vld_q && out_ready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    if (xfer) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + 1'b1;
      end
      if (!col_q[0]) begin
        pair_d = pixel_in;
      end
      // A block can only complete when in_ready held, so a pending result is never overwritten.
      if (blk_done) begin
        pix_d  = avg4(total);
        vld_d  = 1'b1;
        last_d = row_last && col_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      pair_q <= '0;
      pix_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      pair_q <= pair_d;
      pix_q  <= pix_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  // Partial-sum line is written on every even row before it is read, so it needs no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf[lb_idx] <= pair_sum;
    end
  end

  assign pixel_out = pix_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_bin2x2_filter.sv
// Directed bench for bin2x2_filter on a 4x4 frame with hand-computed binned outputs.
module tb_bin2x2_filter;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pixel_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] pixel_out;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  int n_vec = 0;
  int n_err = 0;

  logic [W:0] out_q [$];
  logic [W:0] exp_q [$];
  int         stim  [$];

  bin2x2_filter #(
    .PIXEL_BIT_WIDTH(W),
    .IN_ROWS        (4),
    .IN_COLS        (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pixel_in (pixel_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pixel_out(pixel_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) out_q.push_back({out_last, pixel_out});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int v);
    int k;
    pixel_in = v[W-1:0];
    in_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 200) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed(input bit gaps);
    foreach (stim[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(stim[i]);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic ramp(input int base, input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(base + i);
  endtask

  task automatic ex(input int p, input bit l);
    exp_q.push_back({l, p[W-1:0]});
  endtask

  task automatic expect_outs(input string tag);
    check($sformatf("%s_count", tag), out_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < out_q.size()) begin
        check($sformatf("%s_pix%0d", tag, i), out_q[i][W-1:0], exp_q[i][W-1:0]);
        check($sformatf("%s_last%0d", tag, i), out_q[i][W], exp_q[i][W]);
      end
    end
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int ev;
    reset     = 1'b1;
    in_valid  = 1'b0;
    pixel_in  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_pixel_out", pixel_out, 0);
    check("rst_in_ready", in_ready, 1);

    // Ramp frame with per-input latency checks
    for (int i = 0; i < 16; i++) begin
      send(i);
      case (i)
        5:       ev = 2;
        7:       ev = 4;
        13:      ev = 10;
        15:      ev = 12;
        default: ev = -1;
      endcase
      check($sformatf("t1_vld_after_%0d", i), out_valid, (ev >= 0) ? 1 : 0);
      if (ev >= 0) begin
        check($sformatf("t1_pix_after_%0d", i), pixel_out, ev);
        check($sformatf("t1_last_after_%0d", i), out_last, (i == 15) ? 1 : 0);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    ex(2, 0); ex(4, 0); ex(10, 0); ex(12, 1);
    expect_outs("t1");

    // Full-scale pixels must not wrap
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(4095);
    feed(0);
    ex(4095, 0); ex(4095, 0); ex(4095, 0); ex(4095, 1);
    expect_outs("t2max");

    // Block sum 11 floors to 2
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back((((i / 4) % 2) == 0 && ((i % 4) % 2) == 0) ? 2 : 3);
    feed(0);
    ex(2, 0); ex(2, 0); ex(2, 0); ex(2, 1);
    expect_outs("t2floor");

    // Backpressure on the first output
    for (int i = 0; i < 6; i++) send(i);
    out_ready = 1'b0;
    pixel_in  = 12'd6;
    in_valid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t3_in_ready_held", in_ready, 0);
      check("t3_vld_held", out_valid, 1);
      check("t3_pix_held", pixel_out, 2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(6);
    check("t3_vld_after_release", out_valid, 0);
    for (int i = 7; i < 16; i++) send(i);
    repeat (3) @(posedge clk);
    #1;
    ex(2, 0); ex(4, 0); ex(10, 0); ex(12, 1);
    expect_outs("t3");

    // Random input gaps
    ramp(0, 16);
    feed(1);
    ex(2, 0); ex(4, 0); ex(10, 0); ex(12, 1);
    expect_outs("t4");

    // Two back-to-back frames
    ramp(0, 32);
    feed(0);
    ex(2, 0); ex(4, 0); ex(10, 0); ex(12, 1);
    ex(18, 0); ex(20, 0); ex(26, 0); ex(28, 1);
    expect_outs("t5");

    // Mid-frame reset discards the partial frame
    for (int i = 0; i < 10; i++) send(i);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_vld_after_reset", out_valid, 0);
    check("t6_last_after_reset", out_last, 0);
    check("t6_pix_after_reset", pixel_out, 0);
    out_q.delete();
    ramp(0, 16);
    feed(0);
    ex(2, 0); ex(4, 0); ex(10, 0); ex(12, 1);
    expect_outs("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin2x2_filter.md
Name: bin2x2_filter

Overview:
- Downstream neighbour of the crop stage: consumes the cropped raster-order pixel stream and emits a 2x2-binned (averaged) stream at half resolution in each dimension.
- Each output pixel is the floor-average of a non-overlapping 2x2 block.
- Uses a one-line partial-sum buffer, row/column counters and a registered valid/ready output.
- Adds an end-of-frame marker for the next stage.

Parameters:
- PIXEL_BIT_WIDTH, 12, bits per pixel in and out.
- IN_ROWS, 20, rows per input frame; must be even and >= 2.
- IN_COLS, 20, columns per input frame; must be even and >= 2.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- pixel_in  input  PIXEL_BIT_WIDTH  input pixel, raster order (row-major, col 0 first).
- in_valid  input  1  pixel_in valid this cycle.
- in_ready  output  1  block can accept pixel_in this cycle.
- pixel_out  output  PIXEL_BIT_WIDTH  binned pixel.
- out_valid  output  1  pixel_out valid.
- out_ready  input  1  downstream accepts pixel_out this cycle.
- out_last  output  1  qualifies pixel_out; high on the final binned pixel of a frame.

Behaviour:
- Accept: input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational, with no dependency on in_valid.
- Counters: col (0..IN_COLS-1) and row (0..IN_ROWS-1) advance only on an input transfer.
  - col wraps to 0 at IN_COLS-1, and row then increments.
  - row wraps to 0 after the last pixel of the frame.
  - Frames are back-to-back with no gap required.
- Horizontal pair: on even col, latch pixel_in into a pair register. On odd col, pair_sum = pair_reg + pixel_in (PIXEL_BIT_WIDTH+1 bits).
- Even row, odd col: write pair_sum to line_buf[col>>1]. line_buf has IN_COLS/2 entries of PIXEL_BIT_WIDTH+1 bits.
- Odd row, odd col:
  - total = line_buf[col>>1] + pair_sum, computed at PIXEL_BIT_WIDTH+2 bits with no overflow.
  - pixel_out <= total >> 2 (floor, truncation).
  - out_valid <= 1.
  - out_last <= (row==IN_ROWS-1 && col==IN_COLS-1).
- Latency: pixel_out is valid on the cycle after the input transfer that completes the block.
- Output register:
  - Held stable (pixel_out, out_last) while out_valid && !out_ready.
  - On an output transfer with no new result, out_valid <= 0 and out_last <= 0.
  - On an output transfer coinciding with a new result, the register loads the new result and out_valid stays 1.
- Output rate: at most one output per 4 inputs, and only on odd rows. in_valid gaps of any length are allowed; state is held.
- Reset:
  - pixel_out=0, out_valid=0, out_last=0.
  - row=0, col=0, pair register=0.
  - line_buf is not reset; every entry is written on an even row before it is read.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).
- pixel_in is ignored when in_valid=0 or in_ready=0.

Test Plan (IN_ROWS=4, IN_COLS=4 override unless noted):
1. Feed pixels 0..15 in raster order, in_valid=1, out_ready=1 → outputs 2, 4, 10, 12 in that order. out_last=1 only on 12. Each output appears 1 cycle after input indices 5, 7, 13, 15 respectively.
2. Feed all pixels = 4095 (max) → four outputs of 4095 with no wrap. Feed all pixels = 3 except one 2 per block → every output = 2 (floor of 11/4).
3. Backpressure: during test 1, hold out_ready=0 when output 2 appears → in_ready=0, pixel_out held at 2, and no inputs are consumed. Release after 5 cycles → 2 transfers, and the stream resumes with identical final outputs.
4. Random in_valid gaps (~50% duty) with out_ready=1 → same output sequence and out_last placement as test 1.
5. Two back-to-back frames (values idx and idx+16) → outputs 2, 4, 10, 12, 18, 20, 26, 28, with out_last on 12 and 28.
6. Assert reset for 1 cycle after input index 9 → out_valid=0 next cycle. A following full frame of 0..15 yields 2, 4, 10, 12 exactly.
